// File: rtl/tlb_cp0_ctrl_pkg.sv
// Shared field widths, CP0 register numbers, op encodings and FSM states for the TLB CP0 front end.
package tlb_cp0_ctrl_pkg;

  localparam int unsigned VPN2_W = 19;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned C_W    = 3;
  localparam int unsigned MASK_W = 16;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_LO0      = 5'd2;
  localparam logic [4:0] CP0_LO1      = 5'd3;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } tlb_state_e;

  // EntryLo payload in its architectural bit order (PFN[25:6] C[5:3] D V G)
  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
    logic             g;
  } entrylo_t;

endpackage

// File: rtl/tlb_cp0_ctrl_random_ctr.sv
// Random register: free-running down counter that wraps within [Wired, TLBNUM-1].
module tlb_cp0_ctrl_random_ctr #(
  parameter int unsigned TLBNUM = 8,
  parameter int unsigned TLB_IW = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [TLB_IW-1:0] i_wired,
  input  logic              i_wired_we,
  output logic [TLB_IW-1:0] o_random
);

  localparam logic [TLB_IW-1:0] RAND_TOP = TLB_IW'(TLBNUM - 1);

  logic [TLB_IW-1:0] r_random;
  logic              w_wrap;

  // Reload at or below the wired boundary; the zero test also covers Wired=0
  assign w_wrap = (r_random <= i_wired) || (r_random == '0);

  // Decrement every cycle; a Wired write restarts from the top
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_random <= RAND_TOP;
    end else if (i_wired_we || w_wrap) begin
      r_random <= RAND_TOP;
    end else begin
      r_random <= r_random - TLB_IW'(1);
    end
  end

  assign o_random = r_random;

endmodule

// File: rtl/tlb_cp0_ctrl.sv
// CP0 TLB-management front end: TLB CP0 registers plus TLBP/TLBR/TLBWI/TLBWR sequencing.
module tlb_cp0_ctrl
  import tlb_cp0_ctrl_pkg::*;
#(
  parameter int unsigned TLBNUM = 8,
  parameter int unsigned TLB_IW = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  input  logic [1:0]        op_type,
  output logic              op_ready,
  output logic              op_done,
  input  logic              mtc0_we,
  input  logic [4:0]        mtc0_addr,
  input  logic [31:0]       mtc0_wdata,
  input  logic [4:0]        mfc0_addr,
  output logic [31:0]       mfc0_rdata,
  output logic [ASID_W-1:0] cur_asid,
  output logic [VPN2_W-1:0] s_vpn2,
  output logic              s_odd_page,
  output logic [ASID_W-1:0] s_asid,
  input  logic              s_found,
  input  logic [TLB_IW-1:0] s_index,
  output logic [TLB_IW-1:0] r_index,
  input  logic [VPN2_W-1:0] r_vpn2,
  input  logic [ASID_W-1:0] r_asid,
  input  logic              r_g,
  input  logic [PFN_W-1:0]  r_pfn0,
  input  logic [C_W-1:0]    r_c0,
  input  logic              r_d0,
  input  logic              r_v0,
  input  logic [PFN_W-1:0]  r_pfn1,
  input  logic [C_W-1:0]    r_c1,
  input  logic              r_d1,
  input  logic              r_v1,
  input  logic [MASK_W-1:0] r_mask,
  output logic              we,
  output logic [TLB_IW-1:0] w_index,
  output logic [VPN2_W-1:0] w_vpn2,
  output logic [ASID_W-1:0] w_asid,
  output logic              w_g,
  output logic [PFN_W-1:0]  w_pfn0,
  output logic [C_W-1:0]    w_c0,
  output logic              w_d0,
  output logic              w_v0,
  output logic [PFN_W-1:0]  w_pfn1,
  output logic [C_W-1:0]    w_c1,
  output logic              w_d1,
  output logic              w_v1,
  output logic [MASK_W-1:0] w_mask
);

  tlb_state_e        r_state;
  tlb_op_e           r_op;
  logic              r_we;
  logic              r_op_done;
  logic              r_op_ready;

  logic              r_idx_p;
  logic [TLB_IW-1:0] r_idx;
  logic [VPN2_W-1:0] r_hi_vpn2;
  logic [ASID_W-1:0] r_hi_asid;
  entrylo_t          r_lo0;
  entrylo_t          r_lo1;
  logic [MASK_W-1:0] r_pmask;
  logic [TLB_IW-1:0] r_wired;

  logic [TLB_IW-1:0] w_random;
  logic              w_wired_we;
  logic              w_exec_p;
  logic              w_exec_r;
  logic [31:0]       w_rdata;

  assign w_wired_we = mtc0_we && (mtc0_addr == CP0_WIRED);
  assign w_exec_p   = (r_state == ST_EXEC) && (r_op == OP_TLBP);
  assign w_exec_r   = (r_state == ST_EXEC) && (r_op == OP_TLBR);

  tlb_cp0_ctrl_random_ctr #(
    .TLBNUM (TLBNUM),
    .TLB_IW (TLB_IW)
  ) u_random_ctr (
    .clk        (clk),
    .resetn     (resetn),
    .i_wired    (r_wired),
    .i_wired_we (w_wired_we),
    .o_random   (w_random)
  );

  // Op sequencer IDLE->EXEC->DONE with registered we/op_done/op_ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_TLBP;
      r_we       <= 1'b0;
      r_op_done  <= 1'b0;
      r_op_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_state    <= ST_EXEC;
            r_op       <= tlb_op_e'(op_type);
            r_we       <= op_type[1];
            r_op_ready <= 1'b0;
          end
        end
        ST_EXEC: begin
          r_state   <= ST_DONE;
          r_we      <= 1'b0;
          r_op_done <= 1'b1;
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_op_done  <= 1'b0;
          r_op_ready <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_we       <= 1'b0;
          r_op_done  <= 1'b0;
          r_op_ready <= 1'b1;
        end
      endcase
    end
  end

  // CP0 register file; op results are applied after mtc0 so they win a same-cycle collision
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx_p   <= 1'b0;
      r_idx     <= '0;
      r_hi_vpn2 <= '0;
      r_hi_asid <= '0;
      r_lo0     <= '0;
      r_lo1     <= '0;
      r_pmask   <= '0;
      r_wired   <= '0;
    end else begin
      if (mtc0_we) begin
        case (mtc0_addr)
          CP0_INDEX:    r_idx   <= mtc0_wdata[TLB_IW-1:0];
          CP0_LO0:      r_lo0   <= mtc0_wdata[25:0];
          CP0_LO1:      r_lo1   <= mtc0_wdata[25:0];
          CP0_PAGEMASK: r_pmask <= mtc0_wdata[28:13];
          CP0_WIRED:    r_wired <= mtc0_wdata[TLB_IW-1:0];
          CP0_ENTRYHI: begin
            r_hi_vpn2 <= mtc0_wdata[31:13];
            r_hi_asid <= mtc0_wdata[7:0];
          end
          default: ;
        endcase
      end
      if (w_exec_p) begin
        r_idx_p <= !s_found;
        if (s_found) begin
          r_idx <= s_index;
        end
      end
      if (w_exec_r) begin
        r_hi_vpn2 <= r_vpn2;
        r_hi_asid <= r_asid;
        r_lo0     <= {r_pfn0, r_c0, r_d0, r_v0, r_g};
        r_lo1     <= {r_pfn1, r_c1, r_d1, r_v1, r_g};
        r_pmask   <= r_mask;
      end
    end
  end

  // mfc0 read mux; unimplemented bits and unlisted registers read zero
  always_comb begin
    w_rdata = '0;
    case (mfc0_addr)
      CP0_INDEX: begin
        w_rdata[31]         = r_idx_p;
        w_rdata[TLB_IW-1:0] = r_idx;
      end
      CP0_RANDOM:   w_rdata[TLB_IW-1:0] = w_random;
      CP0_LO0:      w_rdata[25:0]       = r_lo0;
      CP0_LO1:      w_rdata[25:0]       = r_lo1;
      CP0_PAGEMASK: w_rdata[28:13]      = r_pmask;
      CP0_WIRED:    w_rdata[TLB_IW-1:0] = r_wired;
      CP0_ENTRYHI: begin
        w_rdata[31:13] = r_hi_vpn2;
        w_rdata[7:0]   = r_hi_asid;
      end
      default: ;
    endcase
  end

  assign mfc0_rdata = w_rdata;
  assign op_ready   = r_op_ready;
  assign op_done    = r_op_done;
  assign cur_asid   = r_hi_asid;

  assign s_vpn2     = r_hi_vpn2;
  assign s_odd_page = 1'b0;
  assign s_asid     = r_hi_asid;
  assign r_index    = r_idx;

  // Write port is driven straight from the registers, so an mtc0 in EXEC lands only after the write
  assign we      = r_we;
  assign w_index = (r_op == OP_TLBWR) ? w_random : r_idx;
  assign w_vpn2  = r_hi_vpn2;
  assign w_asid  = r_hi_asid;
  assign w_g     = r_lo0.g & r_lo1.g;
  assign w_pfn0  = r_lo0.pfn;
  assign w_c0    = r_lo0.c;
  assign w_d0    = r_lo0.d;
  assign w_v0    = r_lo0.v;
  assign w_pfn1  = r_lo1.pfn;
  assign w_c1    = r_lo1.c;
  assign w_d1    = r_lo1.d;
  assign w_v1    = r_lo1.v;
  assign w_mask  = r_pmask;

endmodule
